bin_to_bcd_seq: RTL and testbench
=================================

# bin_to_bcd_seq

Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one bit per clock. It sits between the datapath's result registers and the eight-digit seven-segment display driver, so the board shows register contents in decimal rather than hex. A start/done handshake lets the top level convert each 16-bit value independently. The output holds the last completed result, so the display never shows a partial conversion.

## Interface
- `WIDTH`, default 16: binary input width in bits.
- `DIGITS`, default 5: number of BCD output digits. Must satisfy 10^DIGITS > 2^WIDTH − 1.
- `Clk`  input  1: system clock; all state updates on the rising edge.
- `Reset`  input  1: asynchronous, active-high reset.
- `Start`  input  1: request a conversion; sampled only in IDLE.
- `BinIn`  input  WIDTH: value to convert; captured on the accepted Start edge.
- `Busy`  output  1: high while a conversion is in progress.
- `Done`  output  1: one-cycle pulse when BcdOut updates.
- `BcdOut`  output  4*DIGITS: packed BCD result, digit 0 (units) in bits [3:0].
- `Negative`  output  1: sign of the last result. Present only with SIGNED_EN; see Configuration.

## Operation
- States:
  - IDLE → SHIFT on Start.
  - SHIFT → FINISH after WIDTH shift steps.
  - FINISH → IDLE unconditionally.
- Accept:
  - In IDLE with Start=1, latch BinIn into the shift register.
  - Clear the working BCD register to 0.
  - Load the step counter with WIDTH.
- Each SHIFT cycle:
  - Every working digit ≥ 5 gets +3. All digits are corrected in parallel, combinationally.
  - The {BCD, binary} concatenation then shifts left by 1.
  - The step counter decrements. Leave SHIFT when the counter reaches 0.
- FINISH:
  - Copy the working BCD register to BcdOut.
  - Pulse Done for exactly one cycle.
- Start is ignored while Busy=1, including in FINISH. It is not queued.
- BcdOut changes only in FINISH. Between conversions it holds its value indefinitely.
- Digits above the most significant nonzero digit read 0. Blanking those leading zeros is the display driver's job, not this block's.

## Timing
- Reset values:
  - Busy=0, Done=0, BcdOut=0, Negative=0.
  - State IDLE.
  - Working registers 0.
- Start sampled high at edge 0:
  - Busy=1 from edge 0 through edge WIDTH+1.
  - Done=1 and BcdOut valid after edge WIDTH+1 (17 cycles for WIDTH=16).
  - Busy=0 the cycle after Done.
- Back-to-back throughput: one conversion per WIDTH+2 cycles. Start may be held high continuously to re-convert.
- Reset asserted mid-conversion:
  - Abort immediately; all outputs return to reset values.
  - No Done pulse is issued for the aborted conversion.
- BinIn may change freely after the accept edge; the captured copy is used.

## Configuration
- `BIN_TO_BCD_SIGNED_EN` defined:
  - BinIn is two's complement.
  - On accept, the block latches the magnitude (−BinIn when the MSB is 1) and records the sign.
  - Negative updates together with BcdOut in FINISH.
  - The most negative value −2^(WIDTH−1) converts to its full magnitude: 32768 for WIDTH=16.
- Not defined:
  - BinIn is unsigned.
  - The Negative port is absent.

## Structure
- Shared package `bcd_pkg`:
  - State enum (IDLE, SHIFT, FINISH).
  - `BCD_DIGIT_W` = 4.
  - Add-3 threshold constant (5).
- One sub-module, `bcd_add3_digit`: 4-bit in, 4-bit out, adds 3 when the input is ≥ 5. Instantiated DIGITS times by generate.
- Step counter width: $clog2(WIDTH+1).

## Test plan
- Unsigned, BinIn=0x04D2 (1234), Start pulse → Done after 17 cycles, BcdOut=0x01234, Busy low one cycle later.
- BinIn=0xFFFF → BcdOut=0x65535. BinIn=0 → BcdOut=0x00000, and Done still pulses.
- BinIn=1234 accepted, then Start with BinIn=9999 raised at cycle 5 while Busy → ignored. Exactly one Done, BcdOut=0x01234.
- Convert 1234, then assert Reset at cycle 8 of a conversion of 4321 → BcdOut=0, Busy=0, no Done. A fresh Start of 4321 → 0x04321.
- Start held high for 40 cycles with BinIn=42 → Done pulses at cycles 17 and 35, BcdOut=0x00042.
- With BIN_TO_BCD_SIGNED_EN:
  - BinIn=0xFFFF → BcdOut=0x00001, Negative=1.
  - BinIn=0x8000 → BcdOut=0x32768, Negative=1.
  - BinIn=0x7FFF → BcdOut=0x32767, Negative=0.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

  localparam int         BCD_DIGIT_W = 4;
  localparam logic [3:0] ADD3_THRESH = 4'd5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_add3_digit.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is >= 5,
// so that the following left shift carries correctly into the next digit.
module bcd_add3_digit
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] i_digit,
  output logic [BCD_DIGIT_W-1:0] o_digit
);

  // Purely combinational correction; all digits are adjusted in parallel by the top.
  always_comb begin
    o_digit = i_digit;
    if (i_digit >= ADD3_THRESH) o_digit = i_digit + 4'd3;
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter, one shift-and-add-3 step per clock.
// Optional feature macro: BIN_TO_BCD_SIGNED_EN (two's complement input,
// magnitude converted and sign reported on Negative).
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          Start,
  input  logic [WIDTH-1:0]              BinIn,
  output logic                          Busy,
  output logic                          Done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] BcdOut
`ifdef BIN_TO_BCD_SIGNED_EN
  ,
  output logic                          Negative
`endif
);

  localparam int BW    = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_bin;
  logic [BW-1:0]    r_bcd;
  logic [CNT_W-1:0] r_cnt;

  logic [BW-1:0]    w_bcd_adj;
  logic [BW-1:0]    w_bcd_next;
  logic [WIDTH-1:0] w_bin_next;
  logic [WIDTH-1:0] w_load;

  // Correct every working digit in parallel before the shift.
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_add3_digit u_add3 (
      .i_digit (r_bcd[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .o_digit (w_bcd_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // {BCD, binary} shifted left by one; the binary MSB enters the BCD LSB.
  assign {w_bcd_next, w_bin_next} = {w_bcd_adj[BW-2:0], r_bin, 1'b0};

`ifdef BIN_TO_BCD_SIGNED_EN
  logic r_sign;
  // Magnitude of a two's complement input; the most negative value wraps to
  // 2^(WIDTH-1), which is exactly its magnitude when read as unsigned.
  assign w_load = BinIn[WIDTH-1] ? (~BinIn) + WIDTH'(1) : BinIn;
`else
  assign w_load = BinIn;
`endif

  // Control FSM and datapath; outputs are registered and only updated in FINISH.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state  <= IDLE;
      r_bin    <= '0;
      r_bcd    <= '0;
      r_cnt    <= '0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      BcdOut   <= '0;
`ifdef BIN_TO_BCD_SIGNED_EN
      r_sign   <= 1'b0;
      Negative <= 1'b0;
`endif
    end else begin
      Done <= 1'b0;
      case (r_state)
        IDLE: begin
          Busy <= Start;
          if (Start) begin
            r_bin   <= w_load;
            r_bcd   <= '0;
            r_cnt   <= CNT_W'(WIDTH);
            r_state <= SHIFT;
`ifdef BIN_TO_BCD_SIGNED_EN
            r_sign  <= BinIn[WIDTH-1];
`endif
          end
        end
        SHIFT: begin
          r_bcd <= w_bcd_next;
          r_bin <= w_bin_next;
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) r_state <= FINISH;
        end
        FINISH: begin
          // Busy stays high through the Done cycle; it drops in IDLE unless restarted.
          BcdOut   <= r_bcd;
          Done     <= 1'b1;
          r_state  <= IDLE;
`ifdef BIN_TO_BCD_SIGNED_EN
          Negative <= r_sign;
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: stimulus pushes reference results,
// a monitor pops and compares on every Done pulse.
module tb_bin_to_bcd_seq;

  localparam int W = 16;
  localparam int D = 5;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          Start;
  logic [W-1:0]  BinIn;
  logic          Busy;
  logic          Done;
  logic [4*D-1:0] BcdOut;
`ifdef BIN_TO_BCD_SIGNED_EN
  logic          Negative;
`endif

  bin_to_bcd_seq #(.WIDTH(W), .DIGITS(D)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Start    (Start),
    .BinIn    (BinIn),
    .Busy     (Busy),
    .Done     (Done),
    .BcdOut   (BcdOut)
`ifdef BIN_TO_BCD_SIGNED_EN
    ,
    .Negative (Negative)
`endif
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [4*D-1:0] bcd;
    logic           neg;
  } exp_t;

  exp_t q[$];
  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;

  // Reference: decimal digits by repeated division of the (magnitude of the) value.
  function automatic exp_t model(logic [W-1:0] v);
    exp_t        e;
    int unsigned mag;
    mag   = v;
    e.neg = 1'b0;
`ifdef BIN_TO_BCD_SIGNED_EN
    if (v[W-1]) begin
      mag   = 65536 - mag;
      e.neg = 1'b1;
    end
`endif
    e.bcd = '0;
    for (int i = 0; i < D; i++) begin
      e.bcd = e.bcd | ((4*D)'(mag % 10) << (4*i));
      mag   = mag / 10;
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every Done pulse must match the oldest outstanding expectation.
  always @(negedge Clk) begin
    if (!Reset && Done) begin
      done_cnt++;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got BcdOut %h expected no Done", BcdOut);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("bcd_out", 32'(BcdOut), 32'(e.bcd));
`ifdef BIN_TO_BCD_SIGNED_EN
        chk("negative", 32'(Negative), 32'(e.neg));
`endif
      end
    end
  end

  // Called at a negedge with the DUT idle; returns at the negedge after the accept edge.
  task automatic issue(input logic [W-1:0] v);
    BinIn = v;
    Start = 1'b1;
    @(posedge Clk);
    q.push_back(model(v));
    @(negedge Clk);
    Start = 1'b0;
    BinIn = W'($urandom);
  endtask

  // Counts clock edges after the accept edge until Done is seen (bounded).
  task automatic wait_done(output int n);
    n = 0;
    while (!Done && n < 40) begin
      @(posedge Clk);
      n++;
      @(negedge Clk);
    end
  endtask

  task automatic convert(input logic [W-1:0] v);
    int n;
    issue(v);
    wait_done(n);
    chk("latency", 32'(n), 32'(W + 1));
    chk("busy_in_done_cycle", 32'(Busy), 32'd1);
    @(negedge Clk);
    chk("busy_after_done", 32'(Busy), 32'd0);
    chk("done_single_pulse", 32'(Done), 32'd0);
  endtask

  initial begin
    int d0;
    int n;
    Reset = 1'b1;
    Start = 1'b0;
    BinIn = '0;
    repeat (3) @(negedge Clk);
    chk("reset_busy", 32'(Busy), 32'd0);
    chk("reset_done", 32'(Done), 32'd0);
    chk("reset_bcd", 32'(BcdOut), 32'd0);
`ifdef BIN_TO_BCD_SIGNED_EN
    chk("reset_neg", 32'(Negative), 32'd0);
`endif
    Reset = 1'b0;
    repeat (2) @(negedge Clk);

    // Directed values from the test plan.
    convert(16'd1234);
    convert(16'hFFFF);
    convert(16'h0000);
    convert(16'h8000);
    convert(16'h7FFF);

    // Start raised mid-conversion is ignored.
    d0 = done_cnt;
    issue(16'd1234);
    repeat (4) @(negedge Clk);
    BinIn = 16'd9999;
    Start = 1'b1;
    repeat (4) @(negedge Clk);
    Start = 1'b0;
    wait_done(n);
    repeat (25) @(negedge Clk);
    chk("ignored_start_done_count", 32'(done_cnt - d0), 32'd1);

    // Reset in the middle of a conversion aborts it without a Done.
    convert(16'd1234);
    issue(16'd4321);
    repeat (7) @(negedge Clk);
    Reset = 1'b1;
    #1;
    chk("abort_busy", 32'(Busy), 32'd0);
    chk("abort_done", 32'(Done), 32'd0);
    chk("abort_bcd", 32'(BcdOut), 32'd0);
`ifdef BIN_TO_BCD_SIGNED_EN
    chk("abort_neg", 32'(Negative), 32'd0);
`endif
    q.delete();
    @(negedge Clk);
    Reset = 1'b0;
    d0 = done_cnt;
    repeat (25) @(negedge Clk);
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    convert(16'd4321);

    // Start held high: a new conversion every WIDTH+2 cycles.
    BinIn = 16'd42;
    Start = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge Clk);
      if (k % (W + 2) == 0) q.push_back(model(16'd42));
      @(negedge Clk);
      chk("held_done_pattern", 32'(Done), 32'((k == W + 1) || (k == 2*W + 3)));
    end
    Start = 1'b0;
    n = 0;
    while (q.size() != 0 && n < 40) begin
      @(negedge Clk);
      n++;
    end
    chk("held_queue_drained", 32'(q.size()), 32'd0);
    repeat (2) @(negedge Clk);

    // Randomized values with random idle gaps.
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge Clk);
      convert(W'($urandom));
    end

    repeat (5) @(negedge Clk);
    chk("final_queue_empty", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
